// File: rtl/arcade_input_pkg.sv
// Shared types, key codes and direction helpers for the arcade input mapper.
package arcade_input_pkg;

    typedef enum logic [1:0] {
        RotNone = 2'd0,
        RotCw   = 2'd1,
        RotCcw  = 2'd2,
        RotFlip = 2'd3
    } rotate_e;

    localparam int unsigned DirR  = 0;
    localparam int unsigned DirL  = 1;
    localparam int unsigned DirD  = 2;
    localparam int unsigned DirU  = 3;
    localparam int unsigned Fire1 = 4;
    localparam int unsigned Fire2 = 5;
    localparam int unsigned Fire3 = 6;
    localparam int unsigned Fire4 = 7;

    // Arrow keys are matched on the low byte only, extended or not.
    localparam logic [7:0] KeyArrowUp    = 8'h75;
    localparam logic [7:0] KeyArrowDown  = 8'h72;
    localparam logic [7:0] KeyArrowLeft  = 8'h6B;
    localparam logic [7:0] KeyArrowRight = 8'h74;

    localparam logic [8:0] KeyLCtrl  = 9'h014;
    localparam logic [8:0] KeySpace  = 9'h029;
    localparam logic [8:0] KeyLAlt   = 9'h011;
    localparam logic [8:0] KeyLShift = 9'h012;
    localparam logic [8:0] KeyZ      = 9'h01A;
    localparam logic [8:0] KeyR      = 9'h02D;
    localparam logic [8:0] KeyF      = 9'h02B;
    localparam logic [8:0] KeyD      = 9'h023;
    localparam logic [8:0] KeyG      = 9'h034;
    localparam logic [8:0] KeyA      = 9'h01C;
    localparam logic [8:0] KeyS      = 9'h01B;
    localparam logic [8:0] KeyQ      = 9'h015;
    localparam logic [8:0] KeyW      = 9'h01D;
    localparam logic [8:0] KeyF1     = 9'h005;
    localparam logic [8:0] KeyF2     = 9'h006;
    localparam logic [8:0] Key5      = 9'h02E;
    localparam logic [8:0] Key6      = 9'h036;

    function automatic logic [3:0] rotate_dirs(input logic [3:0] dirs, input rotate_e mode);
        logic [3:0] r;
        r = dirs;
        case (mode)
            RotCw: begin
                r[DirU] = dirs[DirL];
                r[DirD] = dirs[DirR];
                r[DirL] = dirs[DirD];
                r[DirR] = dirs[DirU];
            end
            RotCcw: begin
                r[DirU] = dirs[DirR];
                r[DirD] = dirs[DirL];
                r[DirL] = dirs[DirU];
                r[DirR] = dirs[DirD];
            end
            RotFlip: begin
                r[DirU] = dirs[DirD];
                r[DirD] = dirs[DirU];
                r[DirL] = dirs[DirR];
                r[DirR] = dirs[DirL];
            end
            default: r = dirs;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/coin_pulse_gen.sv
// Rising-edge triggered, non-retriggerable coin pulse of fixed length.
module coin_pulse_gen #(
    parameter int unsigned PulseCycles = 4800
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic src_i,
    output logic pulse_o
);

    localparam int unsigned CntW = $clog2(PulseCycles + 1);
    localparam logic [CntW-1:0] LoadVal = CntW'(PulseCycles);

    logic            src_q;
    logic            pulse_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Edges while the counter runs are dropped, so the pulse never stretches.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else if (src_i && !src_q) begin
            cnt_d = LoadVal;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_q   <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            src_q   <= src_i;
            cnt_q   <= cnt_d;
            pulse_q <= (cnt_q != '0);
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/arcade_input_mapper.sv
// PS/2 + joystick to per-player control vectors with rotation, SOCD, autofire and coin pulses.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS       = 2,
    parameter int unsigned NUM_BUTTONS       = 3,
    parameter int unsigned COIN_PULSE_CYCLES = 4800,
    parameter int unsigned COIN_FROM_START   = 1,
    parameter int unsigned AUTOFIRE_FRAMES   = 2,
    parameter int unsigned SOCD_NEUTRAL      = 0
) (
    input  logic                                    clk_sys,
    input  logic                                    RESET,
    input  logic [64:0]                             ps2_key,
    input  logic [15:0]                             joystick_0,
    input  logic [15:0]                             joystick_1,
    input  logic [1:0]                              rotate,
    input  logic                                    merge_joy,
    input  logic                                    autofire_en,
    input  logic                                    ce_frame,
    output logic [NUM_PLAYERS*(4+NUM_BUTTONS)-1:0]  ctrl_out,
    output logic [NUM_PLAYERS-1:0]                  start_out,
    output logic [NUM_PLAYERS-1:0]                  coin_out
);

    localparam int unsigned CtrlW = 4 + NUM_BUTTONS;
    localparam int unsigned AfW   = $clog2(AUTOFIRE_FRAMES + 1);

    logic       pressed, extended, key_event;
    logic [8:0] code;
    logic       toggle_q, armed_q;
    logic [1:0][7:0] keys_q, keys_d;
    logic       space_q, space_d;
    logic [1:0] start_key_q, start_key_d;
    logic [1:0] coin_key_q, coin_key_d;
    logic [1:0][CtrlW-1:0] raw;
    logic [7:0] p1_keys;

    assign pressed  = ps2_key[15:8] != 8'hF0;
    assign extended = pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
    assign code     = (ps2_key[63:24] != '0) ? 9'h000 : {extended, ps2_key[7:0]};
    // The first cycle after reset only samples the toggle bit so nothing stale replays.
    assign key_event = armed_q && (ps2_key[64] != toggle_q);

    always_comb begin
        keys_d      = keys_q;
        space_d     = space_q;
        start_key_d = start_key_q;
        coin_key_d  = coin_key_q;
        if (key_event) begin
            if (code[7:0] == KeyArrowUp) begin
                keys_d[0][DirU] = pressed;
            end else if (code[7:0] == KeyArrowDown) begin
                keys_d[0][DirD] = pressed;
            end else if (code[7:0] == KeyArrowLeft) begin
                keys_d[0][DirL] = pressed;
            end else if (code[7:0] == KeyArrowRight) begin
                keys_d[0][DirR] = pressed;
            end else begin
                case (code)
                    KeyLCtrl:  keys_d[0][Fire1] = pressed;
                    KeySpace:  space_d          = pressed;
                    KeyLAlt:   keys_d[0][Fire2] = pressed;
                    KeyLShift: keys_d[0][Fire3] = pressed;
                    KeyZ:      keys_d[0][Fire4] = pressed;
                    KeyR:      keys_d[1][DirU]  = pressed;
                    KeyF:      keys_d[1][DirD]  = pressed;
                    KeyD:      keys_d[1][DirL]  = pressed;
                    KeyG:      keys_d[1][DirR]  = pressed;
                    KeyA:      keys_d[1][Fire1] = pressed;
                    KeyS:      keys_d[1][Fire2] = pressed;
                    KeyQ:      keys_d[1][Fire3] = pressed;
                    KeyW:      keys_d[1][Fire4] = pressed;
                    KeyF1:     start_key_d[0]   = pressed;
                    KeyF2:     start_key_d[1]   = pressed;
                    Key5:      coin_key_d[0]    = pressed;
                    Key6:      coin_key_d[1]    = pressed;
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            toggle_q    <= 1'b0;
            armed_q     <= 1'b0;
            keys_q      <= '0;
            space_q     <= 1'b0;
            start_key_q <= '0;
            coin_key_q  <= '0;
        end else begin
            toggle_q    <= ps2_key[64];
            armed_q     <= 1'b1;
            keys_q      <= keys_d;
            space_q     <= space_d;
            start_key_q <= start_key_d;
            coin_key_q  <= coin_key_d;
        end
    end

    always_comb begin
        p1_keys        = keys_q[0];
        p1_keys[Fire1] = keys_q[0][Fire1] | space_q;
        raw[0] = p1_keys[CtrlW-1:0] | joystick_0[CtrlW-1:0];
        raw[1] = keys_q[1][CtrlW-1:0];
        if (NUM_PLAYERS > 1) begin
            if (merge_joy) begin
                raw[0] = raw[0] | joystick_1[CtrlW-1:0];
            end else begin
                raw[1] = raw[1] | joystick_1[CtrlW-1:0];
            end
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [3:0]       dirs_rot, dirs_clean;
        logic             held, held_q, rise, phase_eff, phase_q, phase_d, fire1, coin_src;
        logic [AfW-1:0]   cnt_q, cnt_d, cnt_eff;
        logic [CtrlW-1:0] ctrl_d, ctrl_q;
        logic             start_q;

        assign dirs_rot = rotate_dirs(raw[p][3:0], rotate_e'(rotate));

        always_comb begin
            dirs_clean = dirs_rot;
            if (SOCD_NEUTRAL != 0) begin
                if (dirs_rot[DirU] && dirs_rot[DirD]) begin
                    dirs_clean[DirU] = 1'b0;
                    dirs_clean[DirD] = 1'b0;
                end
                if (dirs_rot[DirL] && dirs_rot[DirR]) begin
                    dirs_clean[DirL] = 1'b0;
                    dirs_clean[DirR] = 1'b0;
                end
            end

            // A fresh press restarts the cadence in the firing phase.
            held      = raw[p][Fire1];
            rise      = held && !held_q;
            phase_eff = rise || phase_q;
            cnt_eff   = rise ? '0 : cnt_q;
            cnt_d     = cnt_eff;
            phase_d   = phase_eff;
            if (ce_frame) begin
                if (cnt_eff == AfW'(AUTOFIRE_FRAMES - 1)) begin
                    cnt_d   = '0;
                    phase_d = !phase_eff;
                end else begin
                    cnt_d = cnt_eff + 1'b1;
                end
            end
            fire1 = autofire_en ? (held && phase_eff) : held;

            ctrl_d        = raw[p];
            ctrl_d[3:0]   = dirs_clean;
            ctrl_d[Fire1] = fire1;
        end

        always_ff @(posedge clk_sys or posedge RESET) begin
            if (RESET) begin
                held_q  <= 1'b0;
                phase_q <= 1'b0;
                cnt_q   <= '0;
                ctrl_q  <= '0;
                start_q <= 1'b0;
            end else begin
                held_q  <= held;
                phase_q <= phase_d;
                cnt_q   <= cnt_d;
                ctrl_q  <= ctrl_d;
                start_q <= start_key_q[p];
            end
        end

        assign coin_src = coin_key_q[p] | (start_key_q[p] & (COIN_FROM_START != 0));

        coin_pulse_gen #(
            .PulseCycles(COIN_PULSE_CYCLES)
        ) u_coin (
            .clk_i  (clk_sys),
            .rst_i  (RESET),
            .src_i  (coin_src),
            .pulse_o(coin_out[p])
        );

        assign ctrl_out[p*CtrlW +: CtrlW] = ctrl_q;
        assign start_out[p]               = start_q;
    end

    logic unused_bits;
    assign unused_bits = ^{joystick_0[15:CtrlW], joystick_1[15:CtrlW], keys_q, raw,
                           start_key_q, coin_key_q};

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench with a frame/cycle-level behavioural model compared every cycle.
module tb_arcade_input_mapper;

    localparam int unsigned NP   = 2;
    localparam int unsigned NB   = 3;
    localparam int unsigned CP   = 4;
    localparam int unsigned AF   = 2;
    localparam int unsigned CW   = 4 + NB;

    logic           clk_sys = 1'b0;
    logic           RESET = 1'b1;
    logic [64:0]    ps2_key = '0;
    logic [15:0]    joystick_0 = '0;
    logic [15:0]    joystick_1 = '0;
    logic [1:0]     rotate = '0;
    logic           merge_joy = 1'b0;
    logic           autofire_en = 1'b0;
    logic           ce_frame = 1'b0;
    logic [NP*CW-1:0] ctrl_out;
    logic [NP-1:0]  start_out;
    logic [NP-1:0]  coin_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper #(
        .NUM_PLAYERS      (NP),
        .NUM_BUTTONS      (NB),
        .COIN_PULSE_CYCLES(CP),
        .COIN_FROM_START  (1),
        .AUTOFIRE_FRAMES  (AF),
        .SOCD_NEUTRAL     (1)
    ) dut (
        .clk_sys    (clk_sys),
        .RESET      (RESET),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .rotate     (rotate),
        .merge_joy  (merge_joy),
        .autofire_en(autofire_en),
        .ce_frame   (ce_frame),
        .ctrl_out   (ctrl_out),
        .start_out  (start_out),
        .coin_out   (coin_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [511:0]     m_keys = '0;
    bit               m_armed = 0;
    bit               m_tog = 0;
    int               m_cyc = 0;
    int               m_last[2];
    bit               m_acc[2];
    bit               m_src_prev[2];
    bit               m_held_prev[2];
    int               m_frames[2];
    logic [NP*CW-1:0] exp_ctrl = '0;
    logic [NP-1:0]    exp_start = '0;
    logic [NP-1:0]    exp_coin = '0;

    function automatic bit k(input logic [8:0] c);
        return m_keys[c];
    endfunction

    function automatic logic [CW-1:0] m_raw(input int p);
        logic [7:0] v;
        if (p == 0) begin
            v = {k(9'h01A), k(9'h012), k(9'h011), k(9'h014) | k(9'h029),
                 k(9'h075), k(9'h072), k(9'h06B), k(9'h074)};
            v = v | joystick_0[7:0];
            if (merge_joy) v = v | joystick_1[7:0];
        end else begin
            v = {k(9'h01D), k(9'h015), k(9'h01B), k(9'h01C),
                 k(9'h02D), k(9'h02B), k(9'h023), k(9'h034)};
            if (!merge_joy) v = v | joystick_1[7:0];
        end
        return v[CW-1:0];
    endfunction

    // d = {U, D, L, R}
    function automatic logic [3:0] m_rot(input logic [3:0] d, input logic [1:0] mode);
        bit u, dn, l, r;
        u = d[3]; dn = d[2]; l = d[1]; r = d[0];
        case (mode)
            2'd1: return {l, r, dn, u};
            2'd2: return {r, l, u, dn};
            2'd3: return {dn, u, r, l};
            default: return d;
        endcase
    endfunction

    always @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            m_keys = '0;
            m_armed = 0;
            m_tog = 0;
            exp_ctrl = '0;
            exp_start = '0;
            exp_coin = '0;
            for (int p = 0; p < 2; p++) begin
                m_acc[p] = 0;
                m_src_prev[p] = 0;
                m_held_prev[p] = 0;
                m_frames[p] = 0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                logic [CW-1:0] v;
                logic [3:0]    d;
                bit            held, src;
                v = m_raw(p);
                d = m_rot(v[3:0], rotate);
                if (d[3] && d[2]) d[3:2] = 2'b00;
                if (d[1] && d[0]) d[1:0] = 2'b00;
                held = v[4];
                if (held && !m_held_prev[p]) m_frames[p] = 0;
                v[3:0] = d;
                v[4] = held && (!autofire_en || ((m_frames[p] / AF) % 2 == 0));
                if (ce_frame) m_frames[p]++;
                m_held_prev[p] = held;
                exp_ctrl[p*CW +: CW] = v;

                exp_start[p] = (p == 0) ? k(9'h005) : k(9'h006);
                src = exp_start[p] | ((p == 0) ? k(9'h02E) : k(9'h036));
                if (src && !m_src_prev[p] && !(m_acc[p] && m_cyc <= m_last[p] + CP)) begin
                    m_acc[p] = 1;
                    m_last[p] = m_cyc;
                end
                m_src_prev[p] = src;
                exp_coin[p] = m_acc[p] && m_cyc >= m_last[p] + 1 && m_cyc <= m_last[p] + CP;
            end
            if (!m_armed) begin
                m_armed = 1;
                m_tog = ps2_key[64];
            end else if (ps2_key[64] != m_tog) begin
                bit         pr, ex;
                logic [8:0] c;
                m_tog = ps2_key[64];
                pr = ps2_key[15:8] != 8'hF0;
                ex = pr ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
                c = {ex, ps2_key[7:0]};
                if (ps2_key[63:24] != '0) c = '0;
                if (c[7:0] inside {8'h75, 8'h72, 8'h6B, 8'h74}) c[8] = 1'b0;
                m_keys[c] = pr;
            end
            m_cyc++;
        end
    end

    always @(negedge clk_sys) begin
        check("model_ctrl", ctrl_out, exp_ctrl);
        check("model_start", start_out, exp_start);
        check("model_coin", coin_out, exp_coin);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_sys);
        #2;
    endtask

    task automatic send_key(input logic [39:0] up, input logic [15:0] mid, input logic [7:0] lo);
        ps2_key = {~ps2_key[64], up, mid, lo};
    endtask

    initial begin
        int         hi;
        logic [7:0] pat;

        tick(3);
        check("reset_ctrl", ctrl_out, 0);
        check("reset_start", start_out, 0);
        check("reset_coin", coin_out, 0);
        RESET = 1'b0;
        tick(2);

        joystick_0 = 16'h0008;
        tick();
        check("joy_up", ctrl_out[3], 1);
        rotate = 2'd1;
        tick();
        check("rot_cw", ctrl_out[3:0], 4'b0001);
        rotate = 2'd2;
        tick();
        check("rot_ccw", ctrl_out[3:0], 4'b0010);
        rotate = 2'd3;
        tick();
        check("rot_flip", ctrl_out[3:0], 4'b0100);
        rotate = 2'd0;
        joystick_0 = '0;
        tick();

        send_key(40'h0, 16'h00E0, 8'h75);
        tick();
        check("kbd_latency", ctrl_out[3], 0);
        tick();
        check("kbd_up", ctrl_out[3], 1);
        send_key(40'h0, 16'hE0F0, 8'h75);
        tick(2);
        check("kbd_up_rel", ctrl_out[3], 0);

        send_key(40'h1, 16'h00E0, 8'h75);
        tick(3);
        check("prtscr_ignored", ctrl_out, 0);

        send_key(40'h0, 16'h0000, 8'h2D);
        tick(2);
        check("p2_up", ctrl_out[CW+3], 1);
        check("p2_key_p1_clear", ctrl_out[CW-1:0], 0);
        send_key(40'h0, 16'h00F0, 8'h2D);
        tick(2);

        merge_joy = 1'b1;
        joystick_1 = 16'h0001;
        tick();
        check("merge_p1", ctrl_out[0], 1);
        check("merge_p2", ctrl_out[CW], 0);
        merge_joy = 1'b0;
        tick();
        check("nomerge_p2", ctrl_out[CW], 1);
        joystick_1 = '0;

        joystick_0 = 16'h0003;
        tick();
        check("socd_lr", ctrl_out[1:0], 0);
        joystick_0 = 16'h000D;
        tick();
        check("socd_ud", ctrl_out[3:0], 4'b0001);
        joystick_0 = '0;
        tick(2);

        // F1 press, then a second F1 edge while the pulse is running
        send_key(40'h0, 16'h0000, 8'h05);
        hi = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            hi += int'(coin_out[0]);
            if (i == 1) check("start1", start_out[0], 1);
            if (i == 2) send_key(40'h0, 16'h00F0, 8'h05);
            if (i == 3) send_key(40'h0, 16'h0000, 8'h05);
        end
        check("coin1_len", hi, CP);
        send_key(40'h0, 16'h00F0, 8'h05);
        tick(2);
        check("start1_rel", start_out[0], 0);

        send_key(40'h0, 16'h0000, 8'h36);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            hi += int'(coin_out[1]);
        end
        check("coin2_len", hi, CP);
        send_key(40'h0, 16'h00F0, 8'h36);
        tick(2);

        autofire_en = 1'b1;
        pat = 8'b0011_0011;
        joystick_0 = 16'h0010;
        tick();
        for (int f = 0; f < 8; f++) begin
            tick(3);
            check($sformatf("autofire_f%0d", f), ctrl_out[4], pat[f]);
            ce_frame = 1'b1;
            tick();
            ce_frame = 1'b0;
            tick(3);
        end
        joystick_0 = '0;
        tick();
        check("autofire_rel", ctrl_out[4], 0);
        autofire_en = 1'b0;
        tick(2);

        send_key(40'h0, 16'h0000, 8'h2E);
        tick(4);
        check("coin_pre_reset", coin_out[0], 1);
        #1 RESET = 1'b1;
        #1 check("coin_in_reset", coin_out[0], 0);
        tick(2);
        RESET = 1'b0;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            hi += int'(coin_out[0]);
        end
        check("coin_after_reset", hi, 0);
        check("start_after_reset", start_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
